// File: rtl/unidade_controle_pkg.sv
// rtl/unidade_controle_pkg.sv - shared control constants: states, opcodes, functs, ALU codes, mux selects
//
// Purpose: one place for every encoding the multicycle control unit and the
// cpu datapath must agree on. Imported by unidade_controle and by cpu.
package unidade_controle_pkg;

    // FSM state encoding
    typedef logic [3:0] state_t;

    localparam logic [3:0] ST_FETCH      = 4'd0;
    localparam logic [3:0] ST_FETCH_WAIT = 4'd1;
    localparam logic [3:0] ST_DECODE     = 4'd2;
    localparam logic [3:0] ST_EXEC_R     = 4'd3;
    localparam logic [3:0] ST_WB_R       = 4'd4;
    localparam logic [3:0] ST_EXEC_I     = 4'd5;
    localparam logic [3:0] ST_WB_I       = 4'd6;
    localparam logic [3:0] ST_MEM_ADDR   = 4'd7;
    localparam logic [3:0] ST_LW_READ    = 4'd8;
    localparam logic [3:0] ST_LW_WB      = 4'd9;
    localparam logic [3:0] ST_SW_WRITE   = 4'd10;
    localparam logic [3:0] ST_BRANCH     = 4'd11;
    localparam logic [3:0] ST_JUMP       = 4'd12;
    localparam logic [3:0] ST_EXC_EPC    = 4'd13;
    localparam logic [3:0] ST_EXC_JUMP   = 4'd14;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;

    // ula32 operation codes
    localparam logic [2:0] SEL_LOAD = 3'b000;
    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_SUB  = 3'b010;
    localparam logic [2:0] SEL_AND  = 3'b011;
    localparam logic [2:0] SEL_CMP  = 3'b111;

    // Datapath mux selects
    localparam logic       IORD_PC         = 1'b0;
    localparam logic       IORD_ALUOUT     = 1'b1;
    localparam logic       ULAA_PC         = 1'b0;
    localparam logic       ULAA_A          = 1'b1;
    localparam logic [1:0] ULAB_B          = 2'b00;
    localparam logic [1:0] ULAB_4          = 2'b01;
    localparam logic [1:0] ULAB_SEXT       = 2'b10;
    localparam logic [1:0] ULAB_SEXT_SH2   = 2'b11;
    localparam logic [1:0] PCSRC_ALU       = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;
    localparam logic [1:0] PCSRC_EXC       = 2'b11;
    localparam logic       REGDST_RT       = 1'b0;
    localparam logic       REGDST_RD       = 1'b1;
    localparam logic       MEMTOREG_ALUOUT = 1'b0;
    localparam logic       MEMTOREG_MEM    = 1'b1;
    localparam logic       CAUSE_OVF       = 1'b0;
    localparam logic       CAUSE_INV       = 1'b1;

endpackage

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle MIPS-subset control unit (Moore FSM)
//
// Purpose: sequences fetch/decode/execute/writeback for add, sub, and, addi,
// lw, sw, beq, bne, j, plus overflow / invalid-opcode exceptions.
// Ports:
//   clk, reset (sync, active-high)
//   opcode, funct          instruction fields from Instr_Reg
//   Overflow, Igual        ula32 flags
//   *_write, IRWrite, RegWrite, MemWrite   write enables (forced 0 while reset=1)
//   IorD, seletor_ulaA, seletor_ulaB, Seletor, PC_src, RegDst, MemtoReg   datapath selects
//   exc_cause              0=overflow, 1=invalid opcode; meaningful with EPC_write
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Overflow,
    input  logic       Igual,
    output logic       PC_write,
    output logic       A_write,
    output logic       B_write,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       ALUOut_write,
    output logic       EPC_write,
    output logic       IorD,
    output logic       seletor_ulaA,
    output logic [1:0] seletor_ulaB,
    output logic [2:0] Seletor,
    output logic [1:0] PC_src,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       exc_cause
);

    state_t     state_q, state_d;
    // Decoded in DECODE and held so EXEC_R/BRANCH outputs depend on state only.
    logic [2:0] alu_sel_q, alu_sel_d;
    logic       is_bne_q, is_bne_d;
    logic       cause_q, cause_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            alu_sel_q <= SEL_LOAD;
            is_bne_q  <= 1'b0;
            cause_q   <= CAUSE_OVF;
        end else begin
            state_q   <= state_d;
            alu_sel_q <= alu_sel_d;
            is_bne_q  <= is_bne_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = ST_FETCH;
        alu_sel_d = alu_sel_q;
        is_bne_d  = is_bne_q;
        cause_d   = cause_q;
        case (state_q)
            ST_FETCH:      state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        state_d = ST_EXEC_R;
                        case (funct)
                            FN_ADD:  alu_sel_d = SEL_ADD;
                            FN_SUB:  alu_sel_d = SEL_SUB;
                            FN_AND:  alu_sel_d = SEL_AND;
                            default: begin
                                state_d = ST_EXC_EPC;
                                cause_d = CAUSE_INV;
                            end
                        endcase
                    end
                    OP_ADDI:      state_d = ST_EXEC_I;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ: begin
                        state_d  = ST_BRANCH;
                        is_bne_d = 1'b0;
                    end
                    OP_BNE: begin
                        state_d  = ST_BRANCH;
                        is_bne_d = 1'b1;
                    end
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        state_d = ST_EXC_EPC;
                        cause_d = CAUSE_INV;
                    end
                endcase
            end
            ST_EXEC_R: begin
                // 'and' cannot overflow; ignore whatever the flag shows for it.
                if (Overflow && (alu_sel_q != SEL_AND)) begin
                    state_d = ST_EXC_EPC;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = ST_WB_R;
                end
            end
            ST_EXEC_I: begin
                if (Overflow) begin
                    state_d = ST_EXC_EPC;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = ST_WB_I;
                end
            end
            ST_MEM_ADDR:   state_d = (opcode == OP_LW) ? ST_LW_READ : ST_SW_WRITE;
            ST_LW_READ:    state_d = ST_LW_WB;
            ST_EXC_EPC:    state_d = ST_EXC_JUMP;
            default:       state_d = ST_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        PC_write     = 1'b0;
        A_write      = 1'b0;
        B_write      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        ALUOut_write = 1'b0;
        EPC_write    = 1'b0;
        IorD         = IORD_PC;
        seletor_ulaA = ULAA_PC;
        seletor_ulaB = ULAB_B;
        Seletor      = SEL_LOAD;
        PC_src       = PCSRC_ALU;
        RegDst       = REGDST_RT;
        MemtoReg     = MEMTOREG_ALUOUT;
        exc_cause    = CAUSE_OVF;
        case (state_q)
            ST_FETCH: begin
                seletor_ulaB = ULAB_4;
                Seletor      = SEL_ADD;
                PC_write     = 1'b1;
            end
            ST_FETCH_WAIT: IRWrite = 1'b1;
            ST_DECODE: begin
                // Precompute the branch target into ALUOut while registers load.
                A_write      = 1'b1;
                B_write      = 1'b1;
                ALUOut_write = 1'b1;
                seletor_ulaB = ULAB_SEXT_SH2;
                Seletor      = SEL_ADD;
            end
            ST_EXEC_R: begin
                seletor_ulaA = ULAA_A;
                Seletor      = alu_sel_q;
                ALUOut_write = 1'b1;
            end
            ST_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = REGDST_RD;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                seletor_ulaA = ULAA_A;
                seletor_ulaB = ULAB_SEXT;
                Seletor      = SEL_ADD;
                ALUOut_write = 1'b1;
            end
            ST_WB_I:       RegWrite = 1'b1;
            ST_LW_READ:    IorD = IORD_ALUOUT;
            ST_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = MEMTOREG_MEM;
            end
            ST_SW_WRITE: begin
                IorD     = IORD_ALUOUT;
                MemWrite = 1'b1;
            end
            ST_BRANCH: begin
                seletor_ulaA = ULAA_A;
                Seletor      = SEL_CMP;
                PC_src       = PCSRC_ALUOUT;
                PC_write     = is_bne_q ? ~Igual : Igual;
            end
            ST_JUMP: begin
                PC_src   = PCSRC_JUMP;
                PC_write = 1'b1;
            end
            ST_EXC_EPC: begin
                // PC was already advanced in FETCH; PC-4 is the faulting instruction.
                seletor_ulaB = ULAB_4;
                Seletor      = SEL_SUB;
                EPC_write    = 1'b1;
                exc_cause    = cause_q;
            end
            ST_EXC_JUMP: begin
                PC_src   = PCSRC_EXC;
                PC_write = 1'b1;
            end
            default: ;
        endcase
        // Reset aborts the current instruction in the very cycle it is seen.
        if (reset) begin
            PC_write     = 1'b0;
            A_write      = 1'b0;
            B_write      = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            MemWrite     = 1'b0;
            ALUOut_write = 1'b0;
            EPC_write    = 1'b0;
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - per-cycle vector bench for unidade_controle
module tb_unidade_controle;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       Overflow = 1'b0;
    logic       Igual = 1'b0;
    logic       PC_write, A_write, B_write, IRWrite, RegWrite, MemWrite, ALUOut_write, EPC_write;
    logic       IorD, seletor_ulaA, RegDst, MemtoReg, exc_cause;
    logic [1:0] seletor_ulaB, PC_src;
    logic [2:0] Seletor;

    unidade_controle dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .Overflow(Overflow), .Igual(Igual),
        .PC_write(PC_write), .A_write(A_write), .B_write(B_write), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUOut_write(ALUOut_write),
        .EPC_write(EPC_write), .IorD(IorD), .seletor_ulaA(seletor_ulaA),
        .seletor_ulaB(seletor_ulaB), .Seletor(Seletor), .PC_src(PC_src),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .exc_cause(exc_cause)
    );

    always #5 clk = ~clk;

    wire [19:0] got = {PC_write, A_write, B_write, IRWrite, RegWrite, MemWrite, ALUOut_write,
                       EPC_write, IorD, seletor_ulaA, seletor_ulaB, Seletor, PC_src,
                       RegDst, MemtoReg, exc_cause};
    localparam logic [19:0] EN_MASK = 20'hFF000;

    function automatic logic [19:0] mk(input logic pcw, aw, bw, irw, rw, mw, aow, epcw,
                                       input logic iord, ua, input logic [1:0] ub,
                                       input logic [2:0] sel, input logic [1:0] ps,
                                       input logic rd, m2r, ec);
        return {pcw, aw, bw, irw, rw, mw, aow, epcw, iord, ua, ub, sel, ps, rd, m2r, ec};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ovf;
        logic        ig;
        logic [19:0] exp;
        logic        en_only;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic [19:0] E_F, E_FW, E_D, E_XADD, E_XSUB, E_XAND, E_WBR, E_XI, E_WBI;
    logic [19:0] E_LWR, E_LWWB, E_SWW, E_BR1, E_BR0, E_J, E_EPCO, E_EPCI, E_EJ;

    task automatic push(input logic r, input logic [5:0] op, fn, input logic ov, ig,
                        input logic [19:0] e, input logic eo, input string nm);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.ovf = ov; v.ig = ig;
        v.exp = e; v.en_only = eo; v.name = nm;
        vecs.push_back(v);
    endtask

    // FETCH, FETCH_WAIT, DECODE common to every instruction
    task automatic pre(input logic [5:0] op, fn, input logic ov, ig, input string nm);
        push(1'b0, op, fn, ov, ig, E_F,  1'b0, {nm, ".fetch"});
        push(1'b0, op, fn, ov, ig, E_FW, 1'b0, {nm, ".fwait"});
        push(1'b0, op, fn, ov, ig, E_D,  1'b0, {nm, ".decode"});
    endtask

    task automatic step(input logic r, input logic [5:0] op, fn, input logic ov, ig,
                        input logic [19:0] e, input logic eo, input string nm);
        logic [19:0] m;
        @(negedge clk);
        reset = r; opcode = op; funct = fn; Overflow = ov; Igual = ig;
        #1;
        m = eo ? EN_MASK : 20'hFFFFF;
        checks++;
        if ((got & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s: got %05h required %05h (mask %05h)", nm, got, e, m);
        end
    endtask

    initial begin
        E_F    = mk(1,0,0,0,0,0,0,0, 0,0,2'b01,3'b001,2'b00, 0,0,0);
        E_FW   = mk(0,0,0,1,0,0,0,0, 0,0,2'b00,3'b000,2'b00, 0,0,0);
        E_D    = mk(0,1,1,0,0,0,1,0, 0,0,2'b11,3'b001,2'b00, 0,0,0);
        E_XADD = mk(0,0,0,0,0,0,1,0, 0,1,2'b00,3'b001,2'b00, 0,0,0);
        E_XSUB = mk(0,0,0,0,0,0,1,0, 0,1,2'b00,3'b010,2'b00, 0,0,0);
        E_XAND = mk(0,0,0,0,0,0,1,0, 0,1,2'b00,3'b011,2'b00, 0,0,0);
        E_WBR  = mk(0,0,0,0,1,0,0,0, 0,0,2'b00,3'b000,2'b00, 1,0,0);
        E_XI   = mk(0,0,0,0,0,0,1,0, 0,1,2'b10,3'b001,2'b00, 0,0,0);
        E_WBI  = mk(0,0,0,0,1,0,0,0, 0,0,2'b00,3'b000,2'b00, 0,0,0);
        E_LWR  = mk(0,0,0,0,0,0,0,0, 1,0,2'b00,3'b000,2'b00, 0,0,0);
        E_LWWB = mk(0,0,0,0,1,0,0,0, 0,0,2'b00,3'b000,2'b00, 0,1,0);
        E_SWW  = mk(0,0,0,0,0,1,0,0, 1,0,2'b00,3'b000,2'b00, 0,0,0);
        E_BR1  = mk(1,0,0,0,0,0,0,0, 0,1,2'b00,3'b111,2'b01, 0,0,0);
        E_BR0  = mk(0,0,0,0,0,0,0,0, 0,1,2'b00,3'b111,2'b01, 0,0,0);
        E_J    = mk(1,0,0,0,0,0,0,0, 0,0,2'b00,3'b000,2'b10, 0,0,0);
        E_EPCO = mk(0,0,0,0,0,0,0,1, 0,0,2'b01,3'b010,2'b00, 0,0,0);
        E_EPCI = mk(0,0,0,0,0,0,0,1, 0,0,2'b01,3'b010,2'b00, 0,0,1);
        E_EJ   = mk(1,0,0,0,0,0,0,0, 0,0,2'b00,3'b000,2'b11, 0,0,0);

        // Reset held three cycles: no write enables
        for (int i = 0; i < 3; i++) push(1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 20'd0, 1'b1, "reset_hold");
        // add
        pre(6'b000000, 6'b100000, 1'b0, 1'b0, "add");
        push(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0, E_XADD, 1'b0, "add.exec");
        push(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b0, E_WBR,  1'b0, "add.wb");
        // sub
        pre(6'b000000, 6'b100010, 1'b0, 1'b0, "sub");
        push(1'b0, 6'b000000, 6'b100010, 1'b0, 1'b0, E_XSUB, 1'b0, "sub.exec");
        push(1'b0, 6'b000000, 6'b100010, 1'b0, 1'b0, E_WBR,  1'b0, "sub.wb");
        // and with Overflow raised: must still write back
        pre(6'b000000, 6'b100100, 1'b1, 1'b0, "and_ovf");
        push(1'b0, 6'b000000, 6'b100100, 1'b1, 1'b0, E_XAND, 1'b0, "and_ovf.exec");
        push(1'b0, 6'b000000, 6'b100100, 1'b1, 1'b0, E_WBR,  1'b0, "and_ovf.wb");
        // addi
        pre(6'b001000, 6'd0, 1'b0, 1'b0, "addi");
        push(1'b0, 6'b001000, 6'd0, 1'b0, 1'b0, E_XI,  1'b0, "addi.exec");
        push(1'b0, 6'b001000, 6'd0, 1'b0, 1'b0, E_WBI, 1'b0, "addi.wb");
        // lw
        pre(6'b100011, 6'd0, 1'b0, 1'b0, "lw");
        push(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, E_XI,   1'b0, "lw.addr");
        push(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, E_LWR,  1'b0, "lw.read");
        push(1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, E_LWWB, 1'b0, "lw.wb");
        // sw
        pre(6'b101011, 6'd0, 1'b0, 1'b0, "sw");
        push(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, E_XI,  1'b0, "sw.addr");
        push(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, E_SWW, 1'b0, "sw.write");
        // branches, all four Igual combinations
        pre(6'b000100, 6'd0, 1'b0, 1'b1, "beq1");
        push(1'b0, 6'b000100, 6'd0, 1'b0, 1'b1, E_BR1, 1'b0, "beq1.branch");
        pre(6'b000101, 6'd0, 1'b0, 1'b1, "bne1");
        push(1'b0, 6'b000101, 6'd0, 1'b0, 1'b1, E_BR0, 1'b0, "bne1.branch");
        pre(6'b000100, 6'd0, 1'b0, 1'b0, "beq0");
        push(1'b0, 6'b000100, 6'd0, 1'b0, 1'b0, E_BR0, 1'b0, "beq0.branch");
        pre(6'b000101, 6'd0, 1'b0, 1'b0, "bne0");
        push(1'b0, 6'b000101, 6'd0, 1'b0, 1'b0, E_BR1, 1'b0, "bne0.branch");
        // j
        pre(6'b000010, 6'd0, 1'b0, 1'b0, "j");
        push(1'b0, 6'b000010, 6'd0, 1'b0, 1'b0, E_J, 1'b0, "j.jump");
        // addi overflow
        pre(6'b001000, 6'd0, 1'b1, 1'b0, "addi_ovf");
        push(1'b0, 6'b001000, 6'd0, 1'b1, 1'b0, E_XI,   1'b0, "addi_ovf.exec");
        push(1'b0, 6'b001000, 6'd0, 1'b1, 1'b0, E_EPCO, 1'b0, "addi_ovf.epc");
        push(1'b0, 6'b001000, 6'd0, 1'b1, 1'b0, E_EJ,   1'b0, "addi_ovf.excj");
        // sub overflow
        pre(6'b000000, 6'b100010, 1'b1, 1'b0, "sub_ovf");
        push(1'b0, 6'b000000, 6'b100010, 1'b1, 1'b0, E_XSUB, 1'b0, "sub_ovf.exec");
        push(1'b0, 6'b000000, 6'b100010, 1'b1, 1'b0, E_EPCO, 1'b0, "sub_ovf.epc");
        push(1'b0, 6'b000000, 6'b100010, 1'b1, 1'b0, E_EJ,   1'b0, "sub_ovf.excj");
        // invalid opcode
        pre(6'b111111, 6'd0, 1'b0, 1'b0, "inv_op");
        push(1'b0, 6'b111111, 6'd0, 1'b0, 1'b0, E_EPCI, 1'b0, "inv_op.epc");
        push(1'b0, 6'b111111, 6'd0, 1'b0, 1'b0, E_EJ,   1'b0, "inv_op.excj");
        // invalid R-type funct (slt)
        pre(6'b000000, 6'b101010, 1'b0, 1'b0, "inv_fn");
        push(1'b0, 6'b000000, 6'b101010, 1'b0, 1'b0, E_EPCI, 1'b0, "inv_fn.epc");
        push(1'b0, 6'b000000, 6'b101010, 1'b0, 1'b0, E_EJ,   1'b0, "inv_fn.excj");

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].ovf, vecs[i].ig,
                 vecs[i].exp, vecs[i].en_only, vecs[i].name);

        // Reset pulse during SW_WRITE: no MemWrite, then a clean FETCH
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, E_F,    1'b0, "swrst.fetch");
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, E_FW,   1'b0, "swrst.fwait");
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, E_D,    1'b0, "swrst.decode");
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, E_XI,   1'b0, "swrst.addr");
        step(1'b1, 6'b101011, 6'd0, 1'b0, 1'b0, 20'd0,  1'b1, "swrst.write_aborted");
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, E_F,    1'b0, "swrst.refetch");
        step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, E_FW,   1'b0, "swrst.refwait");

        // Reset pulse during EXC_EPC: no EPC_write, exception abandoned
        step(1'b0, 6'b001000, 6'd0, 1'b1, 1'b0, E_D,    1'b0, "excrst.decode");
        step(1'b0, 6'b001000, 6'd0, 1'b1, 1'b0, E_XI,   1'b0, "excrst.exec");
        step(1'b1, 6'b001000, 6'd0, 1'b1, 1'b0, 20'd0,  1'b1, "excrst.epc_aborted");
        step(1'b0, 6'b001000, 6'd0, 1'b0, 1'b0, E_F,    1'b0, "excrst.refetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
